mist_sd_responder: RTL

- Target (IO-controller) end of the sector handshake used by the Disk II track buffer.
- Accepts sector requests (sd_lba, sd_rd, sd_wr) and drives sd_ack, sd_buff_addr, sd_buff_dout and sd_buff_wr.
- Moves 512-byte sectors to and from a byte-wide backing-store port (SDRAM-backed disk image).
- Used for simulation and for boards without an ARM IO controller.

---
 rtl/mist_sd_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mist_sd_responder.sv
// mist_sd_responder
// Target end of the Disk II sector handshake. Accepts a sector request
// (sd_lba with sd_rd or sd_wr), raises sd_ack for the transfer and moves
// 512 bytes between the requester's sector buffer and a byte-wide
// backing-store port holding the disk image.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   sd_lba, sd_rd/wr    sector request (levels, held until sd_ack)
//   sd_ack              transfer in progress
//   sd_buff_addr        byte index within the sector
//   sd_buff_dout/wr     read data and one-cycle write strobe to requester
//   sd_buff_din         write data from requester (registered buffer read)
//   mem_*               one-outstanding-access byte port to backing store
//   busy                high from request accept until back in IDLE
//   oor                 one-cycle pulse: accepted lba is outside the image
module mist_sd_responder #(
  parameter int AW          = 18,
  parameter int IMG_SECTORS = 455
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   sd_lba,
  input  logic          sd_rd,
  input  logic          sd_wr,
  output logic          sd_ack,
  output logic [8:0]    sd_buff_addr,
  output logic [7:0]    sd_buff_dout,
  input  logic [7:0]    sd_buff_din,
  output logic          sd_buff_wr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          oor
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_RD_REQ    = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_RD_PUT    = 4'd4;
  localparam logic [3:0] S_WR_SETTLE = 4'd5;
  localparam logic [3:0] S_WR_REQ    = 4'd6;
  localparam logic [3:0] S_WR_WAIT   = 4'd7;
  localparam logic [3:0] S_WR_NEXT   = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  logic [3:0]    state_r;
  // Only the low lba bits reach the memory address; the full value is
  // range-checked at accept time and the verdict kept in in_range_r.
  logic [AW-10:0] lba_r;
  logic           is_read_r;
  logic           in_range_r;
  logic           req_in_range_s;

  assign req_in_range_s = (sd_lba < 32'(IMG_SECTORS));
  assign mem_addr       = {lba_r, sd_buff_addr};

  // Transfer sequencer: request accept, per-byte memory access and buffer strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      lba_r        <= '0;
      is_read_r    <= 1'b0;
      in_range_r   <= 1'b0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= 9'd0;
      sd_buff_dout <= 8'd0;
      sd_buff_wr   <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_wdata    <= 8'd0;
      busy         <= 1'b0;
      oor          <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      oor        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      sd_buff_wr <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (sd_rd || sd_wr) begin
            lba_r        <= sd_lba[AW-10:0];
            is_read_r    <= sd_rd;
            in_range_r   <= req_in_range_s;
            oor          <= ~req_in_range_s;
            sd_buff_addr <= 9'd0;
            busy         <= 1'b1;
            state_r      <= S_START;
          end
        end
        S_START: begin
          sd_ack  <= 1'b1;
          state_r <= is_read_r ? S_RD_REQ : S_WR_SETTLE;
        end
        S_RD_REQ: begin
          if (in_range_r) begin
            mem_req <= 1'b1;
            state_r <= S_RD_WAIT;
          end else begin
            // Out-of-image sectors read back as zeros without touching memory.
            sd_buff_dout <= 8'd0;
            sd_buff_wr   <= 1'b1;
            state_r      <= S_RD_PUT;
          end
        end
        S_RD_WAIT: begin
          if (mem_ack) begin
            sd_buff_dout <= mem_rdata;
            sd_buff_wr   <= 1'b1;
            state_r      <= S_RD_PUT;
          end
        end
        S_RD_PUT: begin
          // sd_buff_wr is high for this cycle only; address moves afterwards.
          if (sd_buff_addr == 9'd511) begin
            sd_ack  <= 1'b0;
            state_r <= S_DONE;
          end else begin
            sd_buff_addr <= sd_buff_addr + 9'd1;
            state_r      <= S_RD_REQ;
          end
        end
        S_WR_SETTLE: begin
          // Requester's buffer is registered: data follows the address by one clk.
          state_r <= S_WR_REQ;
        end
        S_WR_REQ: begin
          mem_wdata <= sd_buff_din;
          if (in_range_r) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            state_r <= S_WR_WAIT;
          end else begin
            state_r <= S_WR_NEXT;
          end
        end
        S_WR_WAIT: begin
          if (mem_ack) begin
            state_r <= S_WR_NEXT;
          end
        end
        S_WR_NEXT: begin
          if (sd_buff_addr == 9'd511) begin
            sd_ack  <= 1'b0;
            state_r <= S_DONE;
          end else begin
            sd_buff_addr <= sd_buff_addr + 9'd1;
            state_r      <= S_WR_SETTLE;
          end
        end
        S_DONE: begin
          sd_ack  <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          sd_ack  <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
